name_detector: RTL and testbench
================================

NAME_DETECTOR -- requirements
Module: name_detector

Interface
REQ-001 Parameters: none; target string fixed as ASCII "RITUSHREE" (9 characters, uppercase, case-sensitive).
REQ-002 Port order (positional instantiation SHALL work): eurika, letter, clk, rst.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 letter  input  8  ASCII character, one character sampled per rising clk edge.
REQ-006 eurika  output  8  status: bit7 = detect flag, bits6:4 = 000, bits3:0 = matched-prefix length (0..9).

Function
REQ-007 Block SHALL be a Moore FSM with states S0..S9, where Sk = last k sampled characters equal the first k characters of "RITUSHREE".
REQ-008 Expected next character per state: S0 'R'(0x52), S1 'I'(0x49), S2 'T'(0x54), S3 'U'(0x55), S4 'S'(0x53), S5 'H'(0x48), S6 'R', S7 'E'(0x45), S8 'E'.
REQ-009 Sk with expected character (k=0..8) SHALL go to Sk+1 on the next rising edge.
REQ-010 Mismatch, any state: letter=='R' -> S1; otherwise -> S0.
REQ-011 Overlap exception: S7 ("RITUSHR") with letter=='I' -> S2.
REQ-012 S9 SHALL behave as S0 for the next character: 'R' -> S1, else -> S0; overlapping/back-to-back detection supported.
REQ-013 Lowercase or any non-matching byte SHALL be a mismatch per REQ-010; no case folding.
REQ-014 eurika[3:0] SHALL equal current state index k; eurika[6:4] SHALL be 0.
REQ-015 eurika[7] SHALL be 1 exactly while in S9, i.e. for one clock cycle after the edge sampling the final 'E'; otherwise 0.
REQ-016 eurika SHALL be decoded from the state register only (no combinational path from letter).
REQ-017 Detection latency: eurika = 8'h89 valid after the rising edge that samples the 9th character.
REQ-018 Letter is sampled every cycle; there is no valid/enable handshake.

Reset
REQ-019 rst low SHALL immediately force S0 and eurika = 8'h00, independent of clk.
REQ-020 While rst is low, state SHALL hold S0; first character sampled on the first rising edge after rst goes high.
REQ-021 Reset mid-sequence SHALL discard partial progress; matching restarts from S0.

Verification
REQ-022 Pulse rst low -> eurika = 8'h00 immediately, before any clock edge.
REQ-023 Stream 'a','e','R','I','T','U','S','H','R','E','E','g','k' -> eurika after each edge: 00,00,01,02,03,04,05,06,07,08,89,00,00.
REQ-024 Overlap stream "RITUSHRITUSHREE" -> S7 then 'I' -> 02; single 89 after final 'E', no earlier detect.
REQ-025 "RITUSHREERITUSHREE" back-to-back -> 89 twice, exactly 9 cycles apart, with 01 on the cycle after the first 89.
REQ-026 Lowercase "ritushree" -> eurika stays 00 throughout; "RR" -> 01,01.
REQ-027 Async rst low after "RITUS" (eurika 05), between clock edges -> eurika 00 at once; after release, full "RITUSHREE" -> 89.

Source files
------------

// File: rtl/name_detector_if.sv
// name_detector_if -- character stream bundle for the name detector.
//   letter : ASCII character presented to the detector, one per clock
//   eurika : detector status byte (bit7 detect, bits3:0 matched-prefix length)
// master drives characters and observes status; slave is the detector side.
interface name_detector_if;
  logic [7:0] letter;
  logic [7:0] eurika;

  modport master (output letter, input  eurika);
  modport slave  (input  letter, output eurika);
endinterface

// File: rtl/name_detector.sv
// name_detector -- Moore FSM that spots the ASCII string "RITUSHREE" in a
// byte stream sampled on every rising clock edge (no enable/valid).
// Ports (positional order preserved for drop-in use):
//   eurika : out 8  {detect, 3'b000, matched-prefix length 0..9}
//   letter : in  8  ASCII character sampled each rising edge
//   clk    : in  1  clock
//   rst    : in  1  asynchronous, active-low reset
module name_detector (
  output logic [7:0] eurika,
  input  logic [7:0] letter,
  input  logic       clk,
  input  logic       rst
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8,
    S9 = 4'd9
  } state_t;

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_T = 8'h54;
  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_E = 8'h45;

  state_t     state;
  state_t     state_next;
  state_t     state_adv;
  logic [7:0] expected;
  logic       has_expected;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Character that extends the current match, and the state it leads to.
  always_comb begin
    expected     = '0;
    has_expected = 1'b1;
    state_adv    = S0;
    unique case (state)
      S0: begin expected = CH_R; state_adv = S1; end
      S1: begin expected = CH_I; state_adv = S2; end
      S2: begin expected = CH_T; state_adv = S3; end
      S3: begin expected = CH_U; state_adv = S4; end
      S4: begin expected = CH_S; state_adv = S5; end
      S5: begin expected = CH_H; state_adv = S6; end
      S6: begin expected = CH_R; state_adv = S7; end
      S7: begin expected = CH_E; state_adv = S8; end
      S8: begin expected = CH_E; state_adv = S9; end
      S9: begin has_expected = 1'b0; state_adv = S0; end
      default: begin has_expected = 1'b0; state_adv = S0; end
    endcase
  end

  // On a mismatch the only useful overlaps are "R" (restart at S1) and,
  // from "RITUSHR", an 'I' which keeps "RI" matched (S2). A completed
  // match in S9 is treated like S0 for the following character.
  always_comb begin
    state_next = S0;
    if (has_expected && (letter == expected)) begin
      state_next = state_adv;
    end else if ((state == S7) && (letter == CH_I)) begin
      state_next = S2;
    end else if (letter == CH_R) begin
      state_next = S1;
    end else begin
      state_next = S0;
    end
  end

  // Status is decoded from the state register alone.
  always_comb begin
    eurika      = '0;
    eurika[7]   = (state == S9);
    eurika[3:0] = state;
  end

endmodule

// File: tb/tb_name_detector.sv
module tb_name_detector;

  logic clk;
  logic rst;

  name_detector_if bus ();

  name_detector dut (
    .eurika (bus.eurika),
    .letter (bus.letter),
    .clk    (clk),
    .rst    (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] exp_q[$];
  byte        hist[$];
  byte        target[9];

  int unsigned cyc = 0;
  int unsigned det_cycles[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: longest suffix of recent history that is a prefix of the
  // target; a completed match starts the history afresh.
  function automatic logic [7:0] model_step(input byte c);
    int k;
    bit ok;
    k = 0;
    hist.push_back(c);
    if (hist.size() > 9) void'(hist.pop_front());
    for (int len = hist.size(); len >= 1; len--) begin
      ok = 1'b1;
      for (int i = 0; i < len; i++)
        if (hist[hist.size() - len + i] != target[i]) ok = 1'b0;
      if (ok) begin
        k = len;
        break;
      end
    end
    if (k == 9) hist.delete();
    return {(k == 9), 3'b000, 4'(k)};
  endfunction

  // Called just after an active edge (or before the first one): present the
  // character, predict, then compare once the edge has sampled it.
  task automatic send(input byte c, input string tag);
    logic [7:0] e;
    bus.letter = c;
    exp_q.push_back(model_step(c));
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check_eq(tag, bus.eurika, e);
    if (bus.eurika[7]) det_cycles.push_back(cyc);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send(s[i], tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    string t;
    t = "RITUSHREE";
    for (int i = 0; i < 9; i++) target[i] = t[i];

    // Reset asserted before any clock edge.
    rst = 1'b0;
    bus.letter = 8'h52;
    #2;
    check_eq("reset_immediate", bus.eurika, 8'h00);
    // Clocking while held in reset keeps S0.
    @(posedge clk); #1;
    check_eq("reset_hold", bus.eurika, 8'h00);
    @(posedge clk); #1;
    check_eq("reset_hold2", bus.eurika, 8'h00);
    rst = 1'b1;

    // Basic stream with surrounding noise.
    send_str("aeRITUSHREEgk", "basic");

    // Overlap: "RITUSHR" followed by 'I' keeps "RI".
    det_cycles.delete();
    send_str("RITUSHR", "overlap_pre");
    send("I", "overlap_i");
    check_eq("overlap_i_state", bus.eurika, 8'h02);
    send_str("TUSHREE", "overlap_post");
    check_eq("overlap_det_count", det_cycles.size(), 1);
    check_eq("overlap_final", bus.eurika, 8'h89);

    // Back-to-back detection.
    det_cycles.delete();
    send_str("RITUSHREE", "b2b_first");
    send("R", "b2b_after");
    check_eq("b2b_after_det", bus.eurika, 8'h01);
    send_str("ITUSHREE", "b2b_second");
    check_eq("b2b_det_count", det_cycles.size(), 2);
    if (det_cycles.size() == 2)
      check_eq("b2b_gap", det_cycles[1] - det_cycles[0], 9);

    // Lowercase is never a match; repeated 'R' stays at S1.
    det_cycles.delete();
    send_str("ritushree", "lower");
    check_eq("lower_no_det", det_cycles.size(), 0);
    send_str("RR", "double_r");
    check_eq("double_r_state", bus.eurika, 8'h01);

    // Asynchronous reset mid-sequence, between clock edges.
    send_str("RITUS", "mid_pre");
    check_eq("mid_state", bus.eurika, 8'h05);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_reset", bus.eurika, 8'h00);
    hist.delete();
    bus.letter = 8'h48;
    @(posedge clk); #1;
    check_eq("async_reset_hold", bus.eurika, 8'h00);
    rst = 1'b1;
    send_str("RITUSHREE", "post_reset");
    check_eq("post_reset_det", bus.eurika, 8'h89);

    // Random stream over target letters plus a few distractors.
    begin
      string alpha;
      alpha = "RITUSHEerx";
      for (int i = 0; i < 400; i++)
        send(alpha[$urandom_range(alpha.len() - 1)], "random");
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
